mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   MEM-stage load/store unit sitting directly upstream of the data memory. Accepts one
//   load/store per handshake from EX/MEM, drives the memory's adr/datain/w/r ports and
//   returns sign/zero-extended load data, tagged with rd, towards MEM/WB.
//   Sub-word stores use read-modify-write on the enclosing aligned doubleword, because
//   the memory always writes 8 bytes.
// PARAMETERS
//   MEM_BYTES  32  memory size in bytes; multiple of 8
//   XLEN       64  data and address width
// PORTS
//   clk          in   1     clock, rising edge
//   rst_n        in   1     asynchronous reset, active low
//   req_valid    in   1     request present
//   req_ready    out  1     unit can accept; high only in IDLE
//   req_we       in   1     1 = store, 0 = load
//   req_funct3   in   3     000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; stores use [1:0]
//   req_addr     in   XLEN  byte address
//   req_wdata    in   XLEN  store data, right-justified
//   req_rd       in   5     destination tag, passed through
//   resp_valid   out  1     one-cycle completion pulse; no backpressure
//   resp_rdata   out  XLEN  extended load data; 0 for stores and faults
//   resp_rd      out  5     tag of the completing request
//   resp_fault   out  1     misaligned, out-of-range or illegal funct3
//   mem_adr      out  XLEN  memory address: always doubleword-aligned base
//   mem_datain   out  XLEN  memory write data
//   mem_w        out  1     memory write enable, sampled at the memory's clk edge
//   mem_r        out  1     memory read enable; memory output is high-Z when low
//   mem_dataout  in   XLEN  memory read data, combinational
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; all resp_* = 0; mem_w=mem_r=0; mem_adr=mem_datain=0;
//     internal regs cleared.
//   Accept: req_valid && req_ready at edge T. Capture we, funct3, addr, wdata, rd.
//     size = 1<<funct3[1:0]; base = addr & ~7; off = addr[2:0].
//   Fault, decided at accept. Any of:
//     - addr % size != 0
//     - addr >= MEM_BYTES
//     - load funct3 == 111
//     - store funct3[2] == 1
//   States:
//     IDLE : req_ready=1. On accept go to:
//              fault       -> RESP
//              load        -> RD
//              store size 8 -> WR
//              other store -> RD
//     RD   : mem_r=1, mem_adr=base. Register mem_dataout at the edge.
//              load -> RESP; store -> WR
//     WR   : mem_w=1, mem_adr=base, mem_datain=merged. -> RESP
//              SD: merged = wdata.
//              Sub-word: merged = rd_buf with bytes [off, off+size-1] replaced by the
//              low size bytes of wdata.
//     RESP : resp_valid=1, resp_rd=rd, resp_fault=fault. -> IDLE
//              Loads: resp_rdata = (rd_buf >> 8*off), truncated to size, then
//              sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1).
//   Latency, accept edge to resp_valid high: fault 1 cycle; load 2; SD 2; SB/SH/SW 3.
//   Throughput: next accept no earlier than the cycle resp_valid is high
//     (RESP -> IDLE, ready next cycle).
//   mem_r and mem_w are never high together. Faulting requests never touch memory.
//   Little-endian byte order throughout.
//   Reset mid-operation: any state -> IDLE immediately. A pending WR is dropped (no
//     mem_w), and no resp_valid is issued for the aborted request.
//   resp_rdata, resp_rd and resp_fault hold their values outside RESP;
//     resp_valid alone qualifies them.
// TESTING
//   1. SD 0x1122334455667788 @8, then LD @8
//      -> mem_w high for exactly 1 cycle with mem_adr=8;
//      -> LD returns 0x1122334455667788, resp 2 cycles after accept.
//   2. After 1, SB wdata=0xAB @13
//      -> RD then WR at mem_adr=8 with mem_datain=0x1122AB4455667788;
//      -> resp 3 cycles after accept; a following LD @8 matches.
//   3. After 2:
//      -> LB @13 = 0xFFFFFFFFFFFFFFAB
//      -> LBU @13 = 0xAB
//      -> LH @14 = 0x1122
//      -> LW @8 = 0x55667788
//   4. Faults: LH @9, LD @32, load funct3=111
//      -> resp_fault=1, resp_rdata=0, resp 1 cycle after accept;
//      -> mem_r=mem_w=0 throughout.
//   5. rst_n low for one cycle while in RD of an SB
//      -> no mem_w pulse, no resp_valid;
//      -> req_ready=1 the cycle after release; memory contents unchanged.
//   6. req_valid held high continuously with 3 back-to-back LDs
//      -> req_ready low in RD/RESP;
//      -> each request accepted once; resp_rd tags appear in order.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of an 8-byte-wide data memory.
// Sub-word stores read-modify-write the enclosing doubleword.
module mem_access_unit #(
    parameter int MEM_BYTES = 32,
    parameter int XLEN      = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic [4:0]      resp_rd,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_adr,
    output logic [XLEN-1:0] mem_datain,
    output logic            mem_w,
    output logic            mem_r,
    input  logic [XLEN-1:0] mem_dataout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [2:0]        off_q, off_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic [4:0]        resp_rd_q, resp_rd_d;
    logic              resp_fault_q, resp_fault_d;
    logic [XLEN-1:0]   mem_adr_q, mem_adr_d;
    logic [XLEN-1:0]   mem_datain_q, mem_datain_d;
    logic              mem_w_q, mem_w_d;
    logic              mem_r_q, mem_r_d;
    logic              misal;
    logic              req_fault;

    // Replace bytes [off, off+size-1] of the old doubleword with store data.
    function automatic logic [XLEN-1:0] merge_bytes(
        input logic [XLEN-1:0] old,
        input logic [XLEN-1:0] wd,
        input logic [2:0]      off,
        input logic [1:0]      sz
    );
        logic [XLEN-1:0] m;
        int              k;
        m = old;
        for (int i = 0; i < 8; i++) begin
            k = i - int'(off);
            if (k >= 0 && k < (1 << sz)) begin
                m[8*i +: 8] = wd[8*k +: 8];
            end
        end
        return m;
    endfunction

    // Align the addressed lane to bit 0, then sign- or zero-extend.
    function automatic logic [XLEN-1:0] load_ext(
        input logic [XLEN-1:0] d,
        input logic [2:0]      off,
        input logic [2:0]      f3
    );
        logic [XLEN-1:0] s;
        logic [XLEN-1:0] r;
        s = d >> {off, 3'b000};
        unique case (f3[1:0])
            2'd0: r = f3[2] ? {{(XLEN-8){1'b0}}, s[7:0]}
                            : {{(XLEN-8){s[7]}}, s[7:0]};
            2'd1: r = f3[2] ? {{(XLEN-16){1'b0}}, s[15:0]}
                            : {{(XLEN-16){s[15]}}, s[15:0]};
            2'd2: r = f3[2] ? {{(XLEN-32){1'b0}}, s[31:0]}
                            : {{(XLEN-32){s[31]}}, s[31:0]};
            2'd3: r = s;
        endcase
        return r;
    endfunction

    // Fault classification of the incoming request.
    always_comb begin
        misal = 1'b0;
        unique case (req_funct3[1:0])
            2'd0: misal = 1'b0;
            2'd1: misal = req_addr[0];
            2'd2: misal = |req_addr[1:0];
            2'd3: misal = |req_addr[2:0];
        endcase
        req_fault = misal
                  || (req_addr >= XLEN'(MEM_BYTES))
                  || (!req_we && req_funct3 == 3'b111)
                  || (req_we && req_funct3[2]);
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        resp_rdata_d = resp_rdata_q;
        resp_rd_d    = resp_rd_q;
        resp_fault_d = resp_fault_q;
        mem_adr_d    = mem_adr_q;
        mem_datain_d = mem_datain_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_addr[2:0];
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    if (req_fault) begin
                        state_d      = RESP;
                        resp_rd_d    = req_rd;
                        resp_fault_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        mem_adr_d = {req_addr[XLEN-1:3], 3'b000};
                        if (req_we && req_funct3[1:0] == 2'b11) begin
                            state_d      = WR;
                            mem_datain_d = req_wdata;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_d      = WR;
                    mem_datain_d = merge_bytes(mem_dataout, wdata_q,
                                               off_q, f3_q[1:0]);
                end else begin
                    state_d      = RESP;
                    resp_rdata_d = load_ext(mem_dataout, off_q, f3_q);
                    resp_rd_d    = rd_q;
                    resp_fault_d = 1'b0;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_rdata_d = '0;
                resp_rd_d    = rd_q;
                resp_fault_d = 1'b0;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_r_d      = (state_d == RD);
        mem_w_d      = (state_d == WR);
        resp_valid_d = (state_d == RESP);
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_fault_q <= 1'b0;
            mem_adr_q    <= '0;
            mem_datain_q <= '0;
            mem_w_q      <= 1'b0;
            mem_r_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rd_q    <= resp_rd_d;
            resp_fault_q <= resp_fault_d;
            mem_adr_q    <= mem_adr_d;
            mem_datain_q <= mem_datain_d;
            mem_w_q      <= mem_w_d;
            mem_r_q      <= mem_r_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_rd    = resp_rd_q;
    assign resp_fault = resp_fault_q;
    assign mem_adr    = mem_adr_q;
    assign mem_datain = mem_datain_q;
    assign mem_w      = mem_w_q;
    assign mem_r      = mem_r_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference model, per-cycle
// compare, directed scenarios and randomized loads/stores.
module tb_mem_access_unit;

    localparam int MB = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_fault;
    logic [63:0] mem_adr;
    logic [63:0] mem_datain;
    logic        mem_w;
    logic        mem_r;
    logic [63:0] mem_dataout;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(MB), .XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_fault(resp_fault),
        .mem_adr(mem_adr), .mem_datain(mem_datain),
        .mem_w(mem_w), .mem_r(mem_r), .mem_dataout(mem_dataout)
    );

    // Data memory seen by the DUT, and the model's own byte image.
    logic [7:0] dmem [MB];
    logic [7:0] rmem [MB];

    always_comb begin
        mem_dataout = '0;
        if (mem_r && mem_adr < 64'(MB)) begin
            for (int i = 0; i < 8; i++) begin
                mem_dataout[8*i +: 8] = dmem[int'(mem_adr[4:0]) + i];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_w && mem_adr < 64'(MB)) begin
            for (int i = 0; i < 8; i++) begin
                dmem[int'(mem_adr[4:0]) + i] = mem_datain[8*i +: 8];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        bit          fault;
        logic [63:0] rdata;
        int          due;
        bit          lit_en;
        logic [63:0] lit_val;
        bit          lit_f;
        bit          din_en;
        logic [63:0] din_val;
    } ent_t;

    ent_t q[$];
    ent_t ce;
    ent_t ne;
    bit   ev;
    int   n_chk = 0;
    int   n_fail = 0;
    int   w_cnt = 0;
    int   exp_w_cnt = 0;
    int   acc_cnt = 0;

    bit          nl_en;
    logic [63:0] nl_val;
    bit          nl_f;
    bit          nd_en;
    logic [63:0] nd_val;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_fault(input bit we, input logic [2:0] f3,
                                   input logic [63:0] a);
        int sz;
        sz = 1 << f3[1:0];
        return (a % sz != 0) || (a >= 64'(MB))
            || (!we && f3 == 3'd7) || (we && f3[2]);
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3,
                                           input logic [63:0] a);
        int          sz;
        logic [63:0] v;
        sz = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < sz; i++) begin
            v = v | (64'(rmem[int'(a) + i]) << (8 * i));
        end
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
        return v;
    endfunction

    function automatic logic [63:0] m_dw(input ent_t e);
        int          base;
        int          sz;
        logic [7:0]  b [8];
        logic [63:0] r;
        base = int'(e.addr) & ~7;
        sz = 1 << e.f3[1:0];
        for (int i = 0; i < 8; i++) b[i] = rmem[base + i];
        for (int i = 0; i < sz; i++) begin
            b[int'(e.addr) - base + i] = e.wdata[8*i +: 8];
        end
        for (int i = 0; i < 8; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    // Per-cycle compare against the model, then record any accept.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready", 64'(req_ready), 64'(q.size() == 0));
            ev = (q.size() > 0) && (q[0].due == cyc);
            chk("resp_valid", 64'(resp_valid), 64'(ev));
            chk("mem_rw_excl", 64'(mem_r && mem_w), 64'd0);
            if (q.size() == 0 || q[0].fault) begin
                chk("mem_idle", {62'd0, mem_r, mem_w}, 64'd0);
            end else if (mem_r || mem_w) begin
                chk("mem_adr", mem_adr, q[0].addr & ~64'd7);
                chk("sd_no_read", 64'(mem_r && q[0].we
                    && q[0].f3[1:0] == 2'b11), 64'd0);
                if (mem_w) begin
                    chk("mem_w_store", 64'(q[0].we), 64'd1);
                    if (q[0].we) chk("mem_datain", mem_datain, m_dw(q[0]));
                    if (q[0].din_en) chk("mem_datain_lit", mem_datain,
                                         q[0].din_val);
                end
            end
            if (mem_w) w_cnt++;
            if (ev) begin
                ce = q.pop_front();
                chk("resp_rd", 64'(resp_rd), 64'(ce.rd));
                chk("resp_fault", 64'(resp_fault), 64'(ce.fault));
                chk("resp_rdata", resp_rdata, ce.rdata);
                if (ce.lit_en) begin
                    chk("rdata_lit", resp_rdata, ce.lit_val);
                    chk("fault_lit", 64'(resp_fault), 64'(ce.lit_f));
                end
                if (ce.we && !ce.fault) begin
                    for (int i = 0; i < (1 << ce.f3[1:0]); i++) begin
                        rmem[int'(ce.addr) + i] = ce.wdata[8*i +: 8];
                    end
                    exp_w_cnt++;
                end
            end else if (q.size() > 0 && q[0].due < cyc) begin
                void'(q.pop_front());
            end
            if (req_valid && req_ready) begin
                ne.we      = req_we;
                ne.f3      = req_funct3;
                ne.addr    = req_addr;
                ne.wdata   = req_wdata;
                ne.rd      = req_rd;
                ne.fault   = m_fault(req_we, req_funct3, req_addr);
                ne.rdata   = (ne.fault || req_we) ? 64'd0
                           : m_load(req_funct3, req_addr);
                ne.due     = cyc + (ne.fault ? 1 : !req_we ? 2
                           : (req_funct3[1:0] == 2'b11) ? 2 : 3);
                ne.lit_en  = nl_en;
                ne.lit_val = nl_val;
                ne.lit_f   = nl_f;
                ne.din_en  = nd_en;
                ne.din_val = nd_val;
                q.push_back(ne);
                acc_cnt++;
            end
        end
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 40; k++) begin
            if (q.size() == 0 && req_ready) break;
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", 64'(q.size() == 0), 64'd1);
    endtask

    task automatic send(input bit we, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [4:0] rd, input bit le,
                        input logic [63:0] lv, input bit lf,
                        input bit de, input logic [63:0] dv,
                        input bit do_wait);
        bit seen;
        bit ok;
        nl_en = le; nl_val = lv; nl_f = lf;
        nd_en = de; nd_val = dv;
        req_we = we; req_funct3 = f3; req_addr = a;
        req_wdata = wd; req_rd = rd; req_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            seen = req_ready;
            @(posedge clk);
            #1;
            if (seen) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        nl_en = 1'b0;
        nd_en = 1'b0;
        chk("accept_timeout", 64'(ok), 64'd1);
        if (do_wait) wait_idle();
    endtask

    initial begin
        int          a;
        int          sz;
        bit          we;
        logic [2:0]  f3;
        int          acc0;
        bit          seen;
        bit          ok;
        logic [63:0] dw_d;
        logic [63:0] dw_r;

        for (int i = 0; i < MB; i++) begin
            dmem[i] = 8'($urandom);
            rmem[i] = dmem[i];
        end
        nl_en = 0; nl_val = 0; nl_f = 0; nd_en = 0; nd_val = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_rd", 64'(resp_rd), 64'd0);
        chk("rst_resp_fault", 64'(resp_fault), 64'd0);
        chk("rst_mem_w", 64'(mem_w), 64'd0);
        chk("rst_mem_r", 64'(mem_r), 64'd0);
        chk("rst_mem_adr", mem_adr, 64'd0);
        chk("rst_mem_datain", mem_datain, 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SD then LD of the same doubleword.
        send(1, 3'b011, 8, 64'h1122334455667788, 5'd1,
             1, 64'd0, 0, 1, 64'h1122334455667788, 1);
        send(0, 3'b011, 8, 0, 5'd2, 1, 64'h1122334455667788, 0, 0, 0, 1);

        // SB into the middle of it, read back.
        send(1, 3'b000, 13, 64'h00000000000000AB, 5'd3,
             1, 64'd0, 0, 1, 64'h1122AB4455667788, 1);
        send(0, 3'b011, 8, 0, 5'd4, 1, 64'h1122AB4455667788, 0, 0, 0, 1);

        // Extension variants.
        send(0, 3'b000, 13, 0, 5'd5, 1, 64'hFFFFFFFFFFFFFFAB, 0, 0, 0, 1);
        send(0, 3'b100, 13, 0, 5'd6, 1, 64'h00000000000000AB, 0, 0, 0, 1);
        send(0, 3'b001, 14, 0, 5'd7, 1, 64'h0000000000001122, 0, 0, 0, 1);
        send(0, 3'b010, 8, 0, 5'd8, 1, 64'h0000000055667788, 0, 0, 0, 1);

        // Faults.
        send(0, 3'b001, 9, 0, 5'd9, 1, 64'd0, 1, 0, 0, 1);
        send(0, 3'b011, 32, 0, 5'd10, 1, 64'd0, 1, 0, 0, 1);
        send(0, 3'b111, 0, 0, 5'd11, 1, 64'd0, 1, 0, 0, 1);
        send(1, 3'b100, 0, 64'h55, 5'd12, 1, 64'd0, 1, 0, 0, 1);

        // Reset while an SB sits in RD: dropped silently.
        send(1, 3'b000, 13, 64'hCD, 5'd13, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        send(0, 3'b000, 13, 0, 5'd14, 1, 64'hFFFFFFFFFFFFFFAB, 0, 0, 0, 1);

        // Three back-to-back LDs with req_valid held high.
        acc0 = acc_cnt;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_we = 1'b0;
            req_funct3 = 3'b011;
            req_addr = 64'(8 * k);
            req_rd = 5'(20 + k);
            ok = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                seen = req_ready;
                @(posedge clk);
                #1;
                if (seen) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("b2b_accept", 64'(ok), 64'd1);
        end
        req_valid = 1'b0;
        wait_idle();
        chk("b2b_count", 64'(acc_cnt - acc0), 64'd3);

        // Randomized mix.
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
            sz = 1 << f3[1:0];
            a = $urandom_range(0, 40);
            if ($urandom_range(0, 3) != 0) a = a & ~(sz - 1);
            send(we, f3, 64'(a), {$urandom, $urandom}, 5'($urandom),
                 0, 0, 0, 0, 0, 1);
        end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < MB / 8; d++) begin
            for (int i = 0; i < 8; i++) begin
                dw_d[8*i +: 8] = dmem[8*d + i];
                dw_r[8*i +: 8] = rmem[8*d + i];
            end
            chk("mem_final", dw_d, dw_r);
        end
        chk("mem_w_pulses", 64'(w_cnt), 64'(exp_w_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
